// File: rtl/composite_pkg.sv
// rtl/composite_pkg.sv - shared level encodings, region types and default PAL-like timing
package composite_pkg;

    localparam logic [1:0] LVL_SYNC  = 2'b00;
    localparam logic [1:0] LVL_BLACK = 2'b01;
    localparam logic [1:0] LVL_GREY  = 2'b10;
    localparam logic [1:0] LVL_WHITE = 2'b11;

    typedef enum logic [1:0] {HR_SYNC, HR_BACK, HR_ACTIVE, HR_FRONT} h_region_e;
    typedef enum logic [1:0] {VR_SYNC, VR_BLANK, VR_ACTIVE, VR_BOTTOM} v_region_e;

    localparam int DEF_H_TOTAL  = 64;
    localparam int DEF_H_SYNC   = 5;
    localparam int DEF_H_BACK   = 7;
    localparam int DEF_H_ACTIVE = 50;
    localparam int DEF_V_TOTAL  = 312;
    localparam int DEF_V_VSYNC  = 3;
    localparam int DEF_V_BLANK  = 20;
    localparam int DEF_V_ACTIVE = 256;
    localparam int DEF_XW       = 8;
    localparam int DEF_YW       = 9;

endpackage

// File: rtl/composite_line_counter.sv
// rtl/composite_line_counter.sv - hcnt/vcnt wrap counters and H/V region decode
module composite_line_counter
    import composite_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_VSYNC  = DEF_V_VSYNC,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int HW       = $clog2(H_TOTAL),
    parameter int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pix_ce,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output h_region_e     o_h_region,
    output v_region_e     o_v_region
);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_B_START = HW'(H_SYNC);
    localparam logic [HW-1:0] H_A_START = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_F_START = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_B_START = VW'(V_VSYNC);
    localparam logic [VW-1:0] V_A_START = VW'(V_VSYNC + V_BLANK);
    localparam logic [VW-1:0] V_F_START = VW'(V_VSYNC + V_BLANK + V_ACTIVE);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_pix_ce) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_h_region = HR_FRONT;
        if (r_hcnt < H_B_START)      o_h_region = HR_SYNC;
        else if (r_hcnt < H_A_START) o_h_region = HR_BACK;
        else if (r_hcnt < H_F_START) o_h_region = HR_ACTIVE;

        o_v_region = VR_BOTTOM;
        if (r_vcnt < V_B_START)      o_v_region = VR_SYNC;
        else if (r_vcnt < V_A_START) o_v_region = VR_BLANK;
        else if (r_vcnt < V_F_START) o_v_region = VR_ACTIVE;
    end

    assign o_hcnt = r_hcnt;
    assign o_vcnt = r_vcnt;

endmodule

// File: rtl/composite_timing_gen.sv
// rtl/composite_timing_gen.sv - composite sync/level/pixel-coordinate generator; COMPOSITE_TEST_PATTERN_EN selects bar pattern
module composite_timing_gen
    import composite_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_VSYNC  = DEF_V_VSYNC,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int XW       = DEF_XW,
    parameter int YW       = DEF_YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pix_ce,
    input  logic [1:0]    i_pix_in,
    output logic          o_sync_n,
    output logic [1:0]    o_level,
    output logic          o_active,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_field_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_BROAD_END = HW'(H_TOTAL - H_SYNC);
    localparam logic [HW-1:0] H_A_START   = HW'(H_SYNC + H_BACK);
    localparam logic [VW-1:0] V_A_START   = VW'(V_VSYNC + V_BLANK);

    if (H_SYNC < 1 || H_BACK < 1 || H_TOTAL - H_SYNC - H_BACK - H_ACTIVE < 1) begin : g_bad_h
        $error("composite_timing_gen: horizontal timing out of range");
    end
    if (V_VSYNC < 1 || V_BLANK < 1 || V_VSYNC + V_BLANK + V_ACTIVE > V_TOTAL) begin : g_bad_v
        $error("composite_timing_gen: vertical timing out of range");
    end
    if ((1 << XW) < H_ACTIVE || (1 << YW) < V_ACTIVE) begin : g_bad_xy
        $error("composite_timing_gen: XW/YW too narrow");
    end

    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    h_region_e     w_h_region;
    v_region_e     w_v_region;
    logic          w_sync_lo;
    logic          w_visible;
    logic [HW-1:0] w_hoff;
    logic [VW-1:0] w_voff;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [1:0]    w_pix;

    composite_line_counter #(
        .H_TOTAL (H_TOTAL),  .H_SYNC  (H_SYNC),  .H_BACK  (H_BACK),  .H_ACTIVE(H_ACTIVE),
        .V_TOTAL (V_TOTAL),  .V_VSYNC (V_VSYNC), .V_BLANK (V_BLANK), .V_ACTIVE(V_ACTIVE),
        .HW      (HW),       .VW      (VW)
    ) u_line_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pix_ce   (i_pix_ce),
        .o_hcnt     (w_hcnt),
        .o_vcnt     (w_vcnt),
        .o_h_region (w_h_region),
        .o_v_region (w_v_region)
    );

    // Field-sync lines carry broad pulses: low for all but the last H_SYNC ticks.
    assign w_sync_lo = (w_v_region == VR_SYNC) ? (w_hcnt < H_BROAD_END)
                                               : (w_h_region == HR_SYNC);
    assign w_visible = (w_h_region == HR_ACTIVE) && (w_v_region == VR_ACTIVE);
    assign w_hoff    = w_hcnt - H_A_START;
    assign w_voff    = w_vcnt - V_A_START;
    assign w_x       = w_visible ? XW'(w_hoff) : '0;
    assign w_y       = w_visible ? YW'(w_voff) : '0;

`ifdef COMPOSITE_TEST_PATTERN_EN
    localparam logic [XW-1:0] BAND = XW'(H_ACTIVE / 4);
    logic [1:0] w_band;
    logic       w_unused_pix;
    assign w_band       = 2'(w_x / BAND);
    assign w_unused_pix = ^i_pix_in;

    always_comb begin
        w_pix = LVL_BLACK;
        case (w_band)
            2'd0: w_pix = LVL_BLACK;
            2'd1: w_pix = LVL_GREY;
            2'd2: w_pix = LVL_WHITE;
            2'd3: w_pix = LVL_GREY;
            default: w_pix = LVL_BLACK;
        endcase
        if (w_y == '0) w_pix = LVL_WHITE;
    end
`else
    assign w_pix = (i_pix_in == LVL_SYNC) ? LVL_BLACK : i_pix_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sync_n      <= 1'b1;
            o_level       <= LVL_BLACK;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_field_start <= 1'b0;
        end else begin
            o_field_start <= 1'b0;
            if (i_pix_ce) begin
                o_sync_n      <= ~w_sync_lo;
                o_level       <= w_sync_lo ? LVL_SYNC : (w_visible ? w_pix : LVL_BLACK);
                o_active      <= w_visible;
                o_x           <= w_x;
                o_y           <= w_y;
                o_field_start <= (w_hcnt == '0) && (w_vcnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_composite_timing_gen.sv
// tb/tb_composite_timing_gen.sv - directed self-checking bench for composite_timing_gen
module tb_composite_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_pix_ce = 1'b0;
    logic [1:0] i_pix_in = 2'b01;
    logic       o_sync_n;
    logic [1:0] o_level;
    logic       o_active;
    logic [7:0] o_x;
    logic [8:0] o_y;
    logic       o_field_start;

    int n_checks = 0;
    int n_errors = 0;
    int pres     = -1;
    int fs_seen  = 0;
    int lows[4];
    int lvl_bad  = 0;
    int frz_bad  = 0;
    logic [7:0]  sav_x;
    logic [21:0] sav_all;

    composite_timing_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pix_ce      (i_pix_ce),
        .i_pix_in      (i_pix_in),
        .o_sync_n      (o_sync_n),
        .o_level       (o_level),
        .o_active      (o_active),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_field_start (o_field_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one pixel tick; pres = absolute counter index now shown on the outputs
    task automatic step();
        i_pix_ce = 1'b1;
        @(posedge clk);
        #1;
        i_pix_ce = 1'b0;
        pres++;
        if (o_field_start) fs_seen++;
    endtask

    task automatic idle(input int n);
        i_pix_ce = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to(input int target);
        while (pres < target) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sync_n"}, o_sync_n, 1);
        check({tag, "_level"},  o_level, 2'b01);
        check({tag, "_active"}, o_active, 0);
        check({tag, "_x"},      o_x, 0);
        check({tag, "_y"},      o_y, 0);
        check({tag, "_fs"},     o_field_start, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");

        @(negedge clk);
        rst_n    = 1'b1;
        i_pix_in = 2'b11;
        step();
        check("t0_fs", o_field_start, 1);
        check("t0_sync", o_sync_n, 0);
        check("t0_level", o_level, 2'b00);
        idle(1);
        check("fs_clear", o_field_start, 0);
        check("freeze_sync", o_sync_n, 0);
        fs_seen = 0;

        lows = '{1, 0, 0, 0};
        while (pres < 255) begin
            step();
            lows[pres / 64] += (o_sync_n ? 0 : 1);
            if (o_level !== (o_sync_n ? 2'b01 : 2'b00)) lvl_bad++;
        end
        check("line0_low", lows[0], 59);
        check("line1_low", lows[1], 59);
        check("line2_low", lows[2], 59);
        check("line3_low", lows[3], 5);
        check("blank_level", lvl_bad, 0);

        run_to(23 * 64 + 11);
        check("pre_active", o_active, 0);
        step();
        check("first_active", o_active, 1);
        check("first_x", o_x, 0);
        check("first_y", o_y, 0);

        run_to(23 * 64 + 22);
        check("x10", o_x, 10);
        i_pix_in = 2'b11;
        step();
        check("pix_white", o_level, 2'b11);
        i_pix_in = 2'b00;
        step();
        check("pix_00_black", o_level, 2'b01);
        i_pix_in = 2'b10;
        step();
        check("pix_grey", o_level, 2'b10);
        i_pix_in = 2'b11;

        run_to(23 * 64 + 61);
        check("last_x", o_x, 49);
        check("last_y", o_y, 0);
        check("last_active", o_active, 1);
        step();
        check("front_active", o_active, 0);
        check("front_x", o_x, 0);
        check("front_level", o_level, 2'b01);

        run_to(24 * 64 + 12);
        check("line24_y", o_y, 1);

        run_to(278 * 64 + 30);
        check("l278_active", o_active, 1);
        check("l278_y", o_y, 255);
        check("l278_x", o_x, 18);
        run_to(279 * 64 + 30);
        check("l279_active", o_active, 0);
        check("l279_x", o_x, 0);
        check("l279_y", o_y, 0);
        check("l279_level", o_level, 2'b01);

        run_to(19967);
        check("fs_none_mid", fs_seen, 0);
        step();
        check("fs_period", o_field_start, 1);
        idle(1);
        check("fs_period_clear", o_field_start, 0);

        run_to(19968 + 23 * 64 + 12);
        check("f2_x0", o_x, 0);
        check("f2_active", o_active, 1);
        repeat (10) begin
            step();
            sav_x = o_x;
            for (int i = 0; i < 23; i++) begin
                idle(1);
                if (o_x !== sav_x) frz_bad++;
            end
        end
        check("slow_ce_x", o_x, 10);
        check("slow_ce_freeze", frz_bad, 0);

        sav_all = {o_sync_n, o_level, o_active, o_x, o_y, o_field_start};
        idle(3);
        check("gap3_freeze", {o_sync_n, o_level, o_active, o_x, o_y, o_field_start}, sav_all);

        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        pres  = -1;
        step();
        check("rel_fs", o_field_start, 1);
        check("rel_sync", o_sync_n, 0);
        run_to(58);
        check("rel_broad_low", o_sync_n, 0);
        step();
        check("rel_broad_high", o_sync_n, 1);
        run_to(64);
        check("rel_line1_sync", o_sync_n, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
